// File: rtl/seg_pkg.sv
// Shared constants, state encoding and the BCD-to-segment lookup for the
// multiplexed 7-segment scan driver. All segment values are active-low.
package seg_pkg;

    localparam int MAX_DIGITS = 8;

    // All segments dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All anodes off; callers take the low N_DIGITS bits.
    localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

    typedef enum logic {
        S_GUARD = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_e;

    // Segment order is {g,f,e,d,c,b,a}; non-decimal codes show nothing.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// Combinational BCD digit decoder with a blank override.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Blank wins over the decoded pattern.
    always_comb begin
        seg_o = blank_i ? SEG_BLANK : seg_decode(bcd_i);
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver. A prescaler walks each digit
// slot through an anode-off guard interval and a lit interval; all digits of a
// frame come from one snapshot taken at the frame start.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD_CYC  = 500,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  clr_n_i,
    input  logic                  en_i,
    input  logic                  hold_i,
    input  logic [4*N_DIGITS-1:0] digits_i,
    input  logic [N_DIGITS-1:0]   dp_mask_i,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    scan_state_e              state_q, state_d;
    logic [N_DIGITS-1:0][3:0] snap_q;
    logic [N_DIGITS-1:0]      dp_snap_q;
    logic                     frame_q;
    logic [N_DIGITS-1:0]      an_q, an_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic                     snap_take;
    logic [N_DIGITS-1:0]      lead_blank;
    logic [6:0]               dec_seg;

    // Prescaler: slot counter and digit index; disabled display parks at frame start.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (!en_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Next state: the slot phase follows the counter value it will hold.
    always_comb begin
        state_d = (int'(cnt_d) < GUARD_CYC) ? S_GUARD : S_SHOW;
    end

    // State register together with the prescaler it tracks.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= (GUARD_CYC > 0) ? S_GUARD : S_SHOW;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
        end
    end

    // A frame starts on the first enabled cycle at slot 0 of digit 0.
    assign snap_take = en_i && (cnt_q == '0) && (idx_q == '0) && !hold_i;

    // Snapshot of digits and decimal points, plus the frame pulse.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset like any register.
            snap_q    <= '0;
            dp_snap_q <= '0;
            frame_q   <= 1'b0;
        end else begin
            frame_q <= snap_take;
            if (snap_take) begin
                snap_q    <= digits_i;
                dp_snap_q <= dp_mask_i;
            end
        end
    end

    // Leading-zero mask: digit i>0 blanks when it and every higher digit are zero.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        lead_blank = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero && (snap_q[i] == 4'd0);
            lead_blank[i] = all_zero && BLANK_LEAD;
        end
    end

    bcd_to_seg u_dec (
        .bcd_i   (snap_q[idx_q]),
        .blank_i (lead_blank[idx_q]),
        .seg_o   (dec_seg)
    );

    // Output decode: dark in guard or when disabled, otherwise light the current digit.
    always_comb begin
        an_d  = AN_OFF[N_DIGITS-1:0];
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (en_i && state_q == S_SHOW) begin
            an_d[idx_q] = 1'b0;
            seg_d       = dec_seg;
            dp_d        = ~dp_snap_q[idx_q];
        end
    end

    // Registered drive of the display pins.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            an_q  <= AN_OFF[N_DIGITS-1:0];
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver (4 digits, 4-cycle slots, 1 guard cycle).
// A position-in-frame reference model predicts every output on every cycle.
module tb_seg_scan_driver;

    localparam int N         = 4;
    localparam int SD        = 4;
    localparam int GC        = 1;
    localparam int FRAME_LEN = N * SD;

    logic        clk   = 1'b0;
    logic        clr_n = 1'b0;
    logic        en    = 1'b0;
    logic        hold  = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dpm    = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .N_DIGITS   (N),
        .SCAN_DIV   (SD),
        .GUARD_CYC  (GC),
        .BLANK_LEAD (1'b1)
    ) dut (
        .clk_i     (clk),
        .clr_n_i   (clr_n),
        .en_i      (en),
        .hold_i    (hold),
        .digits_i  (digits),
        .dp_mask_i (dpm),
        .an_o      (an),
        .seg_o     (seg),
        .dp_o      (dp),
        .frame_o   (frame)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: position within the frame and the captured frame data.
    int          m_pos;
    logic [15:0] m_snap;
    logic [3:0]  m_dp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_frame;
    logic [6:0]  seg_lut [16];

    typedef struct packed {
        logic [15:0]     digits;
        logic [3:0]      dpm;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } vec_t;

    vec_t       tbl [7];
    logic [3:0] an_seq [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos   = 0;
        m_snap  = '0;
        m_dp    = '0;
        e_an    = 4'hF;
        e_seg   = 7'h7F;
        e_dp    = 1'b1;
        e_frame = 1'b0;
    endtask

    // Predict the outputs visible after this clock edge from the inputs seen at it.
    task automatic model_edge();
        int slot;
        int phase;
        int top;
        e_frame = 1'b0;
        if (!en) begin
            m_pos = 0;
            e_an  = 4'hF;
            e_seg = 7'h7F;
            e_dp  = 1'b1;
        end else begin
            slot  = m_pos / SD;
            phase = m_pos % SD;
            if (m_pos == 0 && !hold) begin
                m_snap  = digits;
                m_dp    = dpm;
                e_frame = 1'b1;
            end
            if (phase < GC) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end else begin
                top = -1;
                for (int i = 0; i < N; i++)
                    if (m_snap[4*i +: 4] != 4'd0) top = i;
                e_an       = 4'hF;
                e_an[slot] = 1'b0;
                e_seg      = (slot > 0 && slot > top) ? 7'h7F : seg_lut[m_snap[4*slot +: 4]];
                e_dp       = ~m_dp[slot];
            end
            m_pos = (m_pos + 1) % FRAME_LEN;
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("an", 32'(an), 32'(e_an));
        check("seg", 32'(seg), 32'(e_seg));
        check("dp", 32'(dp), 32'(e_dp));
        check("frame", 32'(frame), 32'(e_frame));
    endtask

    // Park the scan for one cycle, then restart it with new inputs.
    task automatic start_scan(input logic [15:0] d, input logic [3:0] m);
        en   = 1'b0;
        hold = 1'b0;
        step();
        digits = d;
        dpm    = m;
        en     = 1'b1;
    endtask

    initial begin
        int frames;
        logic [15:0] rd;
        int nz;

        seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        an_seq  = '{4'hF, 4'hE, 4'hE, 4'hE};
        // seg/dp listed digit 3 down to digit 0
        tbl[0] = '{digits:16'h1259, dpm:4'b0010, seg:{7'h79, 7'h24, 7'h12, 7'h10}, dp:4'b1101};
        tbl[1] = '{digits:16'h0005, dpm:4'b0000, seg:{7'h7F, 7'h7F, 7'h7F, 7'h12}, dp:4'b1111};
        tbl[2] = '{digits:16'h0000, dpm:4'b0000, seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, dp:4'b1111};
        tbl[3] = '{digits:16'h3C07, dpm:4'b1000, seg:{7'h30, 7'h7F, 7'h40, 7'h78}, dp:4'b0111};
        tbl[4] = '{digits:16'h8046, dpm:4'b0100, seg:{7'h00, 7'h40, 7'h19, 7'h02}, dp:4'b1011};
        tbl[5] = '{digits:16'h00F0, dpm:4'b0100, seg:{7'h7F, 7'h7F, 7'h7F, 7'h40}, dp:4'b1011};
        tbl[6] = '{digits:16'h0070, dpm:4'b0001, seg:{7'h7F, 7'h7F, 7'h78, 7'h40}, dp:4'b1110};

        // Reset state, held across clock edges.
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_frame", 32'(frame), 32'h0);

        // Release with the display enabled: one frame pulse, guard then lit digit 0.
        digits = 16'h1259;
        dpm    = 4'b0010;
        en     = 1'b1;
        clr_n  = 1'b1;
        frames = 0;
        for (int k = 0; k < FRAME_LEN; k++) begin
            step();
            if (frame) frames++;
            if (k < 4) check("an_seq", 32'(an), 32'(an_seq[k]));
        end
        check("frame_once", frames, 1);

        // Decode / blanking / decimal point table.
        for (int v = 0; v < 7; v++) begin
            start_scan(tbl[v].digits, tbl[v].dpm);
            for (int k = 0; k < FRAME_LEN; k++) begin
                step();
                if (k % SD == 2) begin
                    check($sformatf("tbl%0d_seg%0d", v, k / SD), 32'(seg), 32'(tbl[v].seg[k / SD]));
                    check($sformatf("tbl%0d_dp%0d", v, k / SD), 32'(dp), 32'(tbl[v].dp[k / SD]));
                end
            end
        end

        // Lap hold: snapshot frozen across a frame boundary, released at the next one.
        start_scan(16'h1259, 4'b0000);
        for (int k = 0; k < 5; k++) step();
        hold   = 1'b1;
        digits = 16'h9999;
        frames = 0;
        for (int k = 5; k < 2 * FRAME_LEN; k++) begin
            step();
            if (frame) frames++;
            if (k == FRAME_LEN + SD + 2) check("hold_old_d1", 32'(seg), 32'h12);
        end
        check("hold_no_frame", frames, 0);
        hold = 1'b0;
        step();
        check("hold_release_frame", 32'(frame), 32'h1);
        for (int k = 1; k <= SD + 2; k++) step();
        check("hold_new_d1", 32'(seg), 32'h10);

        // Inputs change mid-frame: rest of the frame keeps the old snapshot.
        start_scan(16'h1259, 4'b0000);
        for (int k = 0; k < 8; k++) step();
        digits = 16'h4368;
        for (int k = 8; k < FRAME_LEN + 3; k++) begin
            step();
            if (k == 10) check("mid_old_d2", 32'(seg), 32'h24);
            if (k == 14) check("mid_old_d3", 32'(seg), 32'h79);
            if (k == FRAME_LEN + 2) check("mid_new_d0", 32'(seg), 32'h00);
        end

        // Display disabled for 10 cycles, then restart at digit 0 after one guard cycle.
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("en_off_an", 32'(an), 32'hF);
        end
        en = 1'b1;
        step();
        check("en_on_guard", 32'(an), 32'hF);
        step();
        check("en_on_d0", 32'(an), 32'hE);

        // Asynchronous reset in the middle of a lit interval.
        start_scan(16'h1259, 4'b0001);
        for (int k = 0; k < 3; k++) step();
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_an", 32'(an), 32'hF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'h1);
        check("arst_frame", 32'(frame), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_hold_frame", 32'(frame), 32'h0);
        clr_n = 1'b1;
        step();
        check("arst_restart_frame", 32'(frame), 32'h1);
        step();
        check("arst_restart_d0", 32'(an), 32'hE);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            if ($urandom_range(0, 7) == 0) begin
                nz = $urandom_range(0, 4);
                rd = '0;
                for (int i = 0; i < 4; i++)
                    if (i < nz) rd[4*i +: 4] = 4'($urandom_range(0, 11));
                digits = rd;
                dpm    = 4'($urandom_range(0, 15));
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
